// File: rtl/scs8hd_rrarb2_1_if.sv
// scs8hd_rrarb2_1_if
// Request/grant bundle for the two-requester round-robin arbiter.
//   A, B    : requests, driven by the requesters (master side)
//   GA, GB  : one-hot registered grants, driven by the arbiter (slave side)
//   X       : GA | GB, registered resource-busy flag
interface scs8hd_rrarb2_1_if;
    logic A;
    logic B;
    logic GA;
    logic GB;
    logic X;

    modport master (output A, output B, input GA, input GB, input X);
    modport slave  (input A, input B, output GA, output GB, output X);
endinterface

// File: rtl/scs8hd_rrarb2_1.sv
// scs8hd_rrarb2_1
// Two-requester round-robin arbiter. Besides returning the merged request as
// X (any grant active), it resolves ownership of the shared resource and
// returns one-hot registered grants.
// Ports:
//   CLK     : rising-edge clock
//   RESETB  : asynchronous active-low reset
//   bus     : slave side of scs8hd_rrarb2_1_if (A, B in; GA, GB, X out)
//   vpwr, vgnd, vpb, vnb : supply pins, only with SC_USE_PG_PIN
// Parameter:
//   MAX_HOLD : max consecutive grant cycles while the other side waits,
//              0 = unlimited, legal 0..255
//
// state | meaning
// IDLE  | no grant, resource free
// GNT_A | requester A owns the resource
// GNT_B | requester B owns the resource
module scs8hd_rrarb2_1 #(
    parameter int unsigned MAX_HOLD = 4
) (
    input logic CLK,
    input logic RESETB,
`ifdef SC_USE_PG_PIN
    input logic vpwr,
    input logic vgnd,
    input logic vpb,
    input logic vnb,
`endif
    scs8hd_rrarb2_1_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    // Compare value that ends a grant run under contention.
    localparam logic [7:0] HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);
    localparam logic       HOLD_EN   = (MAX_HOLD != 0);

    state_t     state;
    state_t     nxt;
    logic       pri;      // 0 = A favoured on simultaneous requests
    logic [7:0] cnt;
    logic       ga_q;
    logic       gb_q;
    logic       x_q;
    logic       expired;

    assign expired = HOLD_EN && (cnt == HOLD_LAST);

    always_comb begin
        nxt = state;
        case (state)
            IDLE: begin
                if (bus.A && bus.B)
                    nxt = pri ? GNT_B : GNT_A;
                else if (bus.A)
                    nxt = GNT_A;
                else if (bus.B)
                    nxt = GNT_B;
                else
                    nxt = IDLE;
            end
            GNT_A: begin
                if (!bus.A && bus.B)
                    nxt = GNT_B;
                else if (!bus.A)
                    nxt = IDLE;
                else if (bus.B && expired)
                    nxt = GNT_B;
                else
                    nxt = GNT_A;
            end
            GNT_B: begin
                if (!bus.B && bus.A)
                    nxt = GNT_A;
                else if (!bus.B)
                    nxt = IDLE;
                else if (bus.A && expired)
                    nxt = GNT_A;
                else
                    nxt = GNT_B;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            state <= IDLE;
            pri   <= 1'b0;
            cnt   <= 8'd0;
            ga_q  <= 1'b0;
            gb_q  <= 1'b0;
            x_q   <= 1'b0;
        end else begin
            state <= nxt;
            ga_q  <= (nxt == GNT_A);
            gb_q  <= (nxt == GNT_B);
            x_q   <= (nxt != IDLE);
            if (nxt == IDLE) begin
                cnt <= 8'd0;
            end else if (nxt != state) begin
                // new grant: restart the run and favour the other side next
                cnt <= 8'd0;
                pri <= (nxt == GNT_A);
            end else if (cnt != 8'hFF) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

`ifdef SC_USE_PG_PIN
    // vpb/vnb are body ties; only the rails gate the outputs.
    logic pwr_ok;
    assign pwr_ok = (vpwr === 1'b1) && (vgnd === 1'b0);
    assign bus.GA = pwr_ok ? ga_q : 1'bx;
    assign bus.GB = pwr_ok ? gb_q : 1'bx;
    assign bus.X  = pwr_ok ? x_q  : 1'bx;
`else
    assign bus.GA = ga_q;
    assign bus.GB = gb_q;
    assign bus.X  = x_q;
`endif

endmodule

// File: tb/tb_scs8hd_rrarb2_1.sv
module tb_scs8hd_rrarb2_1;

    logic CLK = 1'b0;
    logic RESETB;

    scs8hd_rrarb2_1_if if4 ();
    scs8hd_rrarb2_1_if if0 ();

    scs8hd_rrarb2_1 #(.MAX_HOLD(4)) dut4 (.CLK(CLK), .RESETB(RESETB), .bus(if4.slave));
    scs8hd_rrarb2_1 #(.MAX_HOLD(0)) dut0 (.CLK(CLK), .RESETB(RESETB), .bus(if0.slave));

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic a;
        logic b;
        logic ga;
        logic gb;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check4(input string name, input logic ga, input logic gb);
        check({name, ".GA"}, if4.GA, ga);
        check({name, ".GB"}, if4.GB, gb);
        check({name, ".X"},  if4.X,  ga | gb);
    endtask

    task automatic set_req(input logic a, input logic b);
        if4.A = a; if4.B = b;
        if0.A = a; if0.B = b;
    endtask

    // apply requests, then sample 1 time unit after the next rising edge
    task automatic step(input logic a, input logic b);
        set_req(a, b);
        @(posedge CLK);
        #1;
    endtask

    task automatic reset_pulse();
        set_req(1'b0, 1'b0);
        RESETB = 1'b0;
        #2;
        RESETB = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b1};  // PRI now favours B
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0};  // PRI back to A
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1};  // direct handover, CNT restarts
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b1};  // 4th GB cycle
        vecs[11] = '{1'b1, 1'b1, 1'b1, 0};     // preempt
        vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0};

        RESETB = 1'b0;
        set_req(1'b0, 1'b0);
        repeat (2) @(posedge CLK);
        #1;
        check4("reset", 1'b0, 1'b0);
        check("reset.dut0.X", if0.X, 1'b0);
        RESETB = 1'b1;

        // table-driven vectors, PRI=0 after reset
        for (int i = 0; i < 16; i++) begin
            step(vecs[i].a, vecs[i].b);
            check4($sformatf("vec%0d", i), vecs[i].ga, vecs[i].gb);
        end

        // contention from IDLE with PRI favouring A: runs of 4, starting with A
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 1'b1);
            check4($sformatf("contend%0d", k), ((k / 4) % 2) == 0, ((k / 4) % 2) == 1);
        end
        step(1'b0, 1'b0);
        check4("contend_end", 1'b0, 1'b0);

        // single requester A for 10 cycles
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 1'b0);
            check4($sformatf("single%0d", k), 1'b1, 1'b0);
        end
        step(1'b0, 1'b0);
        check4("single_drop", 1'b0, 1'b0);

        // reset mid-grant (PRI currently favours B)
        step(1'b1, 1'b0);
        check4("pre_reset_grant", 1'b1, 1'b0);
        set_req(1'b1, 1'b1);
        #2;
        RESETB = 1'b0;
        #1;
        check4("async_reset", 1'b0, 1'b0);
        @(posedge CLK);
        #1;
        check4("held_in_reset", 1'b0, 1'b0);
        RESETB = 1'b1;
        step(1'b1, 1'b1);
        check4("post_reset_A_wins", 1'b1, 1'b0);
        step(1'b0, 1'b0);
        check4("post_reset_idle", 1'b0, 1'b0);

        // fairness: single-cycle simultaneous pulses from IDLE after reset
        reset_pulse();
        for (int t = 0; t < 4; t++) begin
            step(1'b1, 1'b1);
            check4($sformatf("fair%0d", t), (t % 2) == 0, (t % 2) == 1);
            step(1'b0, 1'b0);
            check4($sformatf("fair%0d_idle", t), 1'b0, 1'b0);
        end

        // MAX_HOLD=0: holder keeps the grant until it lets go
        reset_pulse();
        for (int k = 0; k < 50; k++) begin
            step(1'b1, 1'b1);
            check($sformatf("nohold%0d.GA", k), if0.GA, 1'b1);
            check($sformatf("nohold%0d.GB", k), if0.GB, 1'b0);
        end
        step(1'b0, 1'b1);
        check("nohold_handover.GA", if0.GA, 1'b0);
        check("nohold_handover.GB", if0.GB, 1'b1);
        check("nohold_handover.X",  if0.X,  1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
